rt_input_unit: RTL and testbench
================================

RT_INPUT_UNIT -- requirements
Module: rt_input_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 512, flit width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-003 SHALL have parameters COORD_W, default 4; MY_X, default 0; MY_Y, default 0 (this router's mesh coordinates).
REQ-004 SHALL use one clock; reset asynchronous, active-high.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 in_req  in  1  upstream 4-phase request, synchronous to clk.
REQ-008 in_data  in  WIDTH  upstream flit, stable while in_req high.
REQ-009 in_ack  out  1  4-phase acknowledge to upstream.
REQ-010 out_valid  out  1  head flit available to switch.
REQ-011 out_ready  in  1  switch consumes head this cycle.
REQ-012 out_data  out  WIDTH  head flit.
REQ-013 out_dir  out  dir_t  routed output direction of head flit.
REQ-014 count  out  $clog2(DEPTH)+1  occupancy.

Function
REQ-015 Header: dest X = in_data[WIDTH-1 -: COORD_W]; dest Y = next COORD_W bits below.
REQ-016 Route: dx = sign(destX-MY_X), dy = sign(destY-MY_Y); (0,0)->LOCAL, (0,+)->NORTH, (0,-)->SOUTH, (+,0)->EAST, (-,0)->WEST, (+,+)->NORTHEAST, (-,+)->NORTHWEST, (+,-)->SOUTHEAST, (-,-)->SOUTHWEST; comparison unsigned.
REQ-017 Direction computed at write time and stored with flit; out_dir always matches out_data.
REQ-018 Input FSM states IDLE, ACKED; reset state IDLE.
REQ-019 IDLE: if in_req=1 and count<DEPTH, write {in_data, dir} at that edge, go ACKED; else stay.
REQ-020 ACKED: in_ack=1 (registered); when in_req=0 sampled, go IDLE, in_ack=0 next cycle.
REQ-021 Latency: req sampled high in cycle N with space -> in_ack=1 in N+1; flit visible (out_valid=1) in N+1 if FIFO was empty.
REQ-022 Full: in_req held high, in_ack held low, no write, until a pop frees space; write then occurs on the first edge where count<DEPTH.
REQ-023 Full determination uses count before the edge; simultaneous pop on a full FIFO does not enable same-edge push.
REQ-024 out_valid = (count!=0); pop when out_valid & out_ready; out_ready ignored when empty.
REQ-025 Simultaneous push and pop (non-full, non-empty): count unchanged, both pointers advance.
REQ-026 Pointers wrap modulo DEPTH; count never exceeds DEPTH nor underflows.
REQ-027 Exactly one write per 4-phase cycle; in_req staying high in ACKED never writes again.
REQ-028 out_data/out_dir undefined-safe when empty: drive stored entry at read pointer, no X from uninitialised memory required.

Reset
REQ-029 On rst: FSM=IDLE, in_ack=0, pointers=0, count=0, out_valid=0; FIFO storage not reset.
REQ-030 Reset mid-handshake aborts it; unacked flit lost; upstream must restart with in_req low then high.
REQ-031 Outputs valid from first edge after rst deasserts.

Structure
REQ-032 dir_t enum (LOCAL, NORTH, SOUTH, EAST, WEST, NORTHEAST, NORTHWEST, SOUTHEAST, SOUTHWEST), 4 bits, SHALL live in router_pkg next to router_type.
REQ-033 COORD_W default and header field offsets SHALL be router_pkg constants.
REQ-034 One sub-module rt_route_calc (combinational XY-diagonal decode, REQ-016) SHALL be instantiated; FIFO and FSM inline.
REQ-035 Ports map one-to-one to RTPort Input modport (in_*), enabling interface binding at top.

Verification
REQ-036 MY=(2,2), send header dest (2,2), out_ready=1 -> in_ack rises N+1, out_valid N+1, out_dir=LOCAL, count returns 0.
REQ-037 Dests (3,2),(1,1),(2,5),(0,3) -> out_dir EAST, SOUTHWEST, NORTH, NORTHWEST in order, data intact.
REQ-038 out_ready=0, DEPTH=4, send 5 flits -> four acked, count=4, fifth in_ack stays 0; pulse out_ready once -> fifth acked one cycle after pop, count=4.
REQ-039 in_req held high 10 cycles after ack -> exactly one write, count=1.
REQ-040 Assert rst while ACKED with count=2 -> in_ack=0, count=0, out_valid=0 immediately; new handshake then succeeds.
REQ-041 Continuous push/pop at count=2 for 2*DEPTH flits -> pointer wrap, FIFO order preserved, count stays 2.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router types: routing directions, router flavour and flit header layout.
package router_pkg;

    typedef enum logic [1:0] {
        RT_MESH_XY   = 2'd0,
        RT_MESH_DIAG = 2'd1
    } router_type;

    typedef enum logic [3:0] {
        LOCAL     = 4'd0,
        NORTH     = 4'd1,
        SOUTH     = 4'd2,
        EAST      = 4'd3,
        WEST      = 4'd4,
        NORTHEAST = 4'd5,
        NORTHWEST = 4'd6,
        SOUTHEAST = 4'd7,
        SOUTHWEST = 4'd8
    } dir_t;

    localparam int unsigned COORD_W_DEF = 4;

    // Header fields sit at the top of the flit, offsets counted in COORD_W units from the MSB
    localparam int unsigned HDR_X_OFS = 0;
    localparam int unsigned HDR_Y_OFS = 1;

    function automatic int unsigned hdr_x_msb(input int unsigned width, input int unsigned cw);
        return width - 1 - HDR_X_OFS * cw;
    endfunction

    function automatic int unsigned hdr_y_msb(input int unsigned width, input int unsigned cw);
        return width - 1 - HDR_Y_OFS * cw;
    endfunction

endpackage

// File: rtl/rt_route_calc.sv
// XY-diagonal route decode: unsigned sign of (dest - here) on each axis picks one of nine directions.
module rt_route_calc
    import router_pkg::*;
#(
    parameter int unsigned COORD_W = COORD_W_DEF,
    parameter int unsigned MY_X    = 0,
    parameter int unsigned MY_Y    = 0
) (
    input  logic [COORD_W-1:0] dest_x,
    input  logic [COORD_W-1:0] dest_y,
    output dir_t               dir_c
);

    localparam logic [COORD_W-1:0] HERE_X = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] HERE_Y = COORD_W'(MY_Y);

    always_comb begin
        dir_c = LOCAL;
        if (dest_x == HERE_X) begin
            if (dest_y > HERE_Y)      dir_c = NORTH;
            else if (dest_y < HERE_Y) dir_c = SOUTH;
            else                      dir_c = LOCAL;
        end else if (dest_x > HERE_X) begin
            if (dest_y > HERE_Y)      dir_c = NORTHEAST;
            else if (dest_y < HERE_Y) dir_c = SOUTHEAST;
            else                      dir_c = EAST;
        end else begin
            if (dest_y > HERE_Y)      dir_c = NORTHWEST;
            else if (dest_y < HERE_Y) dir_c = SOUTHWEST;
            else                      dir_c = WEST;
        end
    end

endmodule

// File: rtl/rt_input_unit.sv
// Router input port: 4-phase upstream handshake into a small FIFO; each flit is stored with its
// routed direction so out_dir always describes out_data.
module rt_input_unit
    import router_pkg::*;
#(
    parameter int unsigned WIDTH   = 512,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned COORD_W = COORD_W_DEF,
    parameter int unsigned MY_X    = 0,
    parameter int unsigned MY_Y    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_req,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ack,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output dir_t                     out_dir,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned X_MSB = hdr_x_msb(WIDTH, COORD_W);
    localparam int unsigned Y_MSB = hdr_y_msb(WIDTH, COORD_W);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rt_input_unit: DEPTH must be a power of two >= 2");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } in_state_t;

    in_state_t          state;
    logic [WIDTH-1:0]   data_mem [DEPTH];
    dir_t               dir_mem  [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;

    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
    dir_t               wr_dir_c;
    logic               push_c;
    logic               pop_c;
    logic [CW-1:0]      count_nxt_c;

    assign dest_x = in_data[X_MSB -: COORD_W];
    assign dest_y = in_data[Y_MSB -: COORD_W];

    rt_route_calc #(
        .COORD_W (COORD_W),
        .MY_X    (MY_X),
        .MY_Y    (MY_Y)
    ) u_route_calc (
        .dest_x (dest_x),
        .dest_y (dest_y),
        .dir_c  (wr_dir_c)
    );

    // Space is judged on the pre-edge count, so a pop on a full FIFO cannot admit a same-edge push
    assign push_c      = (state == IDLE) && in_req && (count < CW'(DEPTH));
    assign pop_c       = out_valid && out_ready;
    assign count_nxt_c = count + CW'(push_c) - CW'(pop_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ack    <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (push_c) begin
                        state  <= ACKED;
                        in_ack <= 1'b1;
                    end
                end
                ACKED: begin
                    if (!in_req) begin
                        state  <= IDLE;
                        in_ack <= 1'b0;
                    end
                end
            endcase
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_nxt_c;
            out_valid <= (count_nxt_c != '0);
        end
    end

    // Flit storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            data_mem[wr_ptr] <= in_data;
            dir_mem[wr_ptr]  <= wr_dir_c;
        end
    end

    assign out_data = data_mem[rd_ptr];
    assign out_dir  = dir_mem[rd_ptr];

endmodule

// File: tb/tb_rt_input_unit.sv
// Self-checking bench for rt_input_unit: directed handshake scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_rt_input_unit;
    import router_pkg::*;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned COORD_W = 4;
    localparam int unsigned MY_X    = 2;
    localparam int unsigned MY_Y    = 2;
    localparam int unsigned CW      = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_req;
    logic [WIDTH-1:0] in_data;
    logic             in_ack;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    dir_t             out_dir;
    logic [CW-1:0]    count;

    rt_input_unit #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .COORD_W (COORD_W),
        .MY_X    (MY_X),
        .MY_Y    (MY_Y)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_req    (in_req),
        .in_data   (in_data),
        .in_ack    (in_ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_dir   (out_dir),
        .count     (count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference route: sign of each axis delta indexes a 3x3 direction table
    function automatic logic [3:0] ref_dir(input logic [WIDTH-1:0] d);
        int   x, y, sx, sy;
        dir_t tbl [3][3];
        tbl = '{'{SOUTHWEST, WEST, NORTHWEST},
                '{SOUTH, LOCAL, NORTH},
                '{SOUTHEAST, EAST, NORTHEAST}};
        x  = int'(d[WIDTH-1 -: COORD_W]);
        y  = int'(d[WIDTH-1-COORD_W -: COORD_W]);
        sx = (x > int'(MY_X)) ? 1 : ((x < int'(MY_X)) ? -1 : 0);
        sy = (y > int'(MY_Y)) ? 1 : ((y < int'(MY_Y)) ? -1 : 0);
        return tbl[sx+1][sy+1];
    endfunction

    function automatic logic [WIDTH-1:0] mk(input int x, input int y, input logic [23:0] p);
        return {4'(x), 4'(y), p};
    endfunction

    // Reference model: a queue of flits plus a single "acknowledged" flag
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [3:0]       dir;
    } ent_t;

    ent_t q[$];
    bit   m_ack;
    bit   full_m, pop_m, push_m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_ack = 1'b0;
        end else begin
            full_m = (q.size() == DEPTH);
            pop_m  = (q.size() != 0) && out_ready;
            push_m = !m_ack && in_req && !full_m;
            if (pop_m) void'(q.pop_front());
            if (push_m) q.push_back('{data: in_data, dir: ref_dir(in_data)});
            if (m_ack) begin
                if (!in_req) m_ack = 1'b0;
            end else if (push_m) begin
                m_ack = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("mon_in_ack", 64'(in_ack), 64'(m_ack));
            check("mon_count", 64'(count), 64'(q.size()));
            check("mon_out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                check("mon_out_data", 64'(out_data), 64'(q[0].data));
                check("mon_out_dir", 64'(out_dir), 64'(q[0].dir));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake(input logic [WIDTH-1:0] d);
        int n;
        in_data = d;
        in_req  = 1'b1;
        n = 0;
        while (in_ack !== 1'b1 && n < 50) begin tick(); n++; end
        check("hs_ack_rise", 64'(in_ack), 64'(1));
        in_req = 1'b0;
        n = 0;
        while (in_ack !== 1'b0 && n < 50) begin tick(); n++; end
        check("hs_ack_fall", 64'(in_ack), 64'(0));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (DEPTH + 1) tick();
        out_ready = 1'b0;
        check("drain_count", 64'(count), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] dq[4];
        dir_t             de[4];
        int               n;

        rst = 1'b1; in_req = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) tick();
        check("rst_in_ack", 64'(in_ack), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        rst = 1'b0;
        tick();

        // Local delivery with the switch always ready
        out_ready = 1'b1;
        in_data = mk(2, 2, 24'hABCDEF);
        in_req = 1'b1;
        tick();
        check("local_ack", 64'(in_ack), 64'(1));
        check("local_valid", 64'(out_valid), 64'(1));
        check("local_dir", 64'(out_dir), 64'(LOCAL));
        check("local_data", 64'(out_data), 64'(mk(2, 2, 24'hABCDEF)));
        in_req = 1'b0;
        tick();
        check("local_count", 64'(count), 64'(0));
        check("local_ack_low", 64'(in_ack), 64'(0));
        out_ready = 1'b0;
        tick();

        // Four destinations, then pop them in order
        dq[0] = mk(3, 2, 24'h000011); de[0] = EAST;
        dq[1] = mk(1, 1, 24'h000022); de[1] = SOUTHWEST;
        dq[2] = mk(2, 5, 24'h000033); de[2] = NORTH;
        dq[3] = mk(0, 3, 24'h000044); de[3] = NORTHWEST;
        for (int i = 0; i < 4; i++) handshake(dq[i]);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("seq_dir", 64'(out_dir), 64'(de[i]));
            check("seq_data", 64'(out_data), 64'(dq[i]));
            tick();
        end
        out_ready = 1'b0;
        check("seq_count", 64'(count), 64'(0));

        // Full FIFO back-pressure: fifth flit waits for a pop
        for (int i = 0; i < 4; i++) handshake(mk(i, 7, 24'(i)));
        check("full_count", 64'(count), 64'(4));
        in_data = mk(9, 0, 24'h555555);
        in_req = 1'b1;
        repeat (5) tick();
        check("full_no_ack", 64'(in_ack), 64'(0));
        check("full_count_held", 64'(count), 64'(4));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("full_pop_no_ack", 64'(in_ack), 64'(0));
        check("full_pop_count", 64'(count), 64'(3));
        tick();
        check("full_late_ack", 64'(in_ack), 64'(1));
        check("full_refill", 64'(count), 64'(4));
        in_req = 1'b0;
        tick();
        drain();

        // Request held high long after the ack must write only once
        in_data = mk(4, 4, 24'h777777);
        in_req = 1'b1;
        tick();
        repeat (10) tick();
        check("hold_one_write", 64'(count), 64'(1));
        in_req = 1'b0;
        tick();
        drain();

        // Reset in the middle of a handshake
        handshake(mk(5, 1, 24'h1));
        in_data = mk(1, 5, 24'h2);
        in_req = 1'b1;
        tick();
        check("pre_rst_count", 64'(count), 64'(2));
        rst = 1'b1;
        #1;
        check("mid_rst_ack", 64'(in_ack), 64'(0));
        check("mid_rst_count", 64'(count), 64'(0));
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        in_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        handshake(mk(0, 0, 24'h3));
        check("post_rst_count", 64'(count), 64'(1));
        check("post_rst_dir", 64'(out_dir), 64'(SOUTHWEST));
        drain();

        // Steady push+pop at occupancy two, across several pointer wraps
        handshake(mk(6, 6, 24'hA0));
        handshake(mk(6, 0, 24'hA1));
        for (int i = 0; i < 2 * DEPTH; i++) begin
            in_data = WIDTH'($urandom);
            in_req = 1'b1;
            out_ready = 1'b1;
            tick();
            check("wrap_count", 64'(count), 64'(2));
            in_req = 1'b0;
            out_ready = 1'b0;
            tick();
        end
        drain();

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!in_req && !in_ack && $urandom_range(0, 2) != 0) begin
                in_data = WIDTH'($urandom);
                in_req = 1'b1;
            end else if (in_req && in_ack) begin
                in_req = 1'b0;
            end
            tick();
        end
        out_ready = 1'b1;
        n = 0;
        while (in_req && !in_ack && n < 20) begin tick(); n++; end
        in_req = 1'b0;
        repeat (2) tick();
        check("rand_ack_idle", 64'(in_ack), 64'(0));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
